logging_capture_writer: RTL and testbench

//  Write side of the datalogging blockram (2048x16). Sample words are buffered in a small FIFO.
//  A wishbone master then writes them into the logging bram at an auto-incrementing pointer.
//  The sbus controls arm/trigger/mode and reads status; the read window reads the captured data back.

---
 rtl/logging_capture_writer_pkg.sv | 46 ++++
 rtl/logging_capture_writer_fifo.sv | 45 ++++
 rtl/logging_capture_writer.sv | 234 +++++++++++++++++++++++
 tb/tb_logging_capture_writer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logging_capture_writer_pkg.sv
// Shared definitions for the datalogging capture path: bram geometry,
// capture FSM encoding, CTRL bit positions and sbus register offsets.
package logging_capture_writer_pkg;

  localparam int DEPTH     = 2048;
  localparam int ADR_W     = 12;
  localparam int FIFO_LOG2 = 2;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  // CTRL write bits
  localparam int CTRL_ARM_BIT   = 0;
  localparam int CTRL_CIRC_BIT  = 1;
  localparam int CTRL_ABORT_BIT = 2;

  // CTRL read bits above the state field
  localparam int STAT_CIRC_BIT = 2;
  localparam int STAT_WRAP_BIT = 3;
  localparam int STAT_OVF_BIT  = 4;

  // sbus register offsets (address bits [2:1])
  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_PTR   = 2'd1;
  localparam logic [1:0] REG_COUNT = 2'd2;
  localparam logic [1:0] REG_RSVD  = 2'd3;

  // Assemble the CTRL/status read word.
  function automatic logic [15:0] pack_status(input cap_state_e st, input logic circ,
                                              input logic wrap, input logic ovf);
    logic [15:0] w;
    w                = 16'h0000;
    w[1:0]           = st;
    w[STAT_CIRC_BIT] = circ;
    w[STAT_WRAP_BIT] = wrap;
    w[STAT_OVF_BIT]  = ovf;
    return w;
  endfunction

endpackage

// File: rtl/logging_capture_writer_fifo.sv
// Small synchronous sample FIFO. The caller only pops when non-empty and only
// pushes into a full FIFO when it pops in the same cycle. Flush has priority.
module logging_sample_fifo #(
  parameter int LOG2 = 2,
  parameter int W    = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] dat_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int N = 1 << LOG2;
  localparam logic [LOG2:0] ONE = {{LOG2{1'b0}}, 1'b1};

  logic [W-1:0]  mem_q [N];
  logic [LOG2:0] wr_q;
  logic [LOG2:0] rd_q;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[LOG2] != rd_q[LOG2]) && (wr_q[LOG2-1:0] == rd_q[LOG2-1:0]);
  assign head_o  = mem_q[rd_q[LOG2-1:0]];

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + ONE;
      if (pop_i)  rd_q <= rd_q + ONE;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q[LOG2-1:0]] <= dat_i;
  end

endmodule

// File: rtl/logging_capture_writer.sv
// Write side of the datalogging blockram: sample FIFO, capture FSM,
// write pointer/count, sbus register file and the bram wishbone master.
// The bram master has its own word register, so one word can be in flight
// while the FIFO holds up to four more.
module logging_capture_writer
  import logging_capture_writer_pkg::*;
(
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             sbus_wb_cyc_i,
  input  logic             sbus_wb_stb_i,
  input  logic             sbus_wb_we_i,
  input  logic [15:0]      sbus_wb_adr_i,
  input  logic [1:0]       sbus_wb_sel_i,
  input  logic [15:0]      sbus_wb_dat_i,
  output logic [15:0]      sbus_wb_dat_o,
  output logic             sbus_wb_ack_o,
  input  logic             sample_valid_i,
  input  logic [15:0]      sample_dat_i,
  input  logic             trig_i,
  output logic             lbram_wb_cyc_o,
  output logic             lbram_wb_stb_o,
  output logic             lbram_wb_we_o,
  output logic [ADR_W-1:0] lbram_wb_adr_o,
  output logic [15:0]      lbram_wb_dat_o,
  input  logic             lbram_wb_ack_i,
  output logic             done_o
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  cap_state_e       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             circ_q, circ_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             stb_q, stb_d;
  logic [15:0]      dat_q, dat_d;
  logic             ack_q;
  logic [15:0]      rdat_q;
  logic [15:0]      rdat_s;

  logic        sbus_req_s, ctrl_wr_s, arm_s, abort_s;
  logic        ack_in_s, last_s, capture_go_s, slot_free_s;
  logic        load_fifo_s, bypass_s, samp_in_s, push_s, pop_s, drop_s, flush_s;
  logic        fifo_full_s, fifo_empty_s;
  logic [15:0] fifo_head_s;
  logic        unused_s;

  assign unused_s = ^{sbus_wb_sel_i, sbus_wb_adr_i[15:3], sbus_wb_adr_i[0]};

  // sbus decode: write side effects commit at the end of the ack cycle.
  assign sbus_req_s = sbus_wb_cyc_i && sbus_wb_stb_i && !ack_q;
  assign ctrl_wr_s  = sbus_wb_cyc_i && sbus_wb_stb_i && sbus_wb_we_i && ack_q &&
                      (sbus_wb_adr_i[2:1] == REG_CTRL);
  // Arm is held off while an aborted write is still waiting for its ack.
  assign arm_s   = ctrl_wr_s && sbus_wb_dat_i[CTRL_ARM_BIT] && !stb_q &&
                   ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign abort_s = ctrl_wr_s && sbus_wb_dat_i[CTRL_ABORT_BIT] &&
                   ((state_q == ST_ARMED) || (state_q == ST_CAPTURE));

  // Bram master handshake and the data path feeding it.
  assign ack_in_s     = stb_q && lbram_wb_ack_i;
  assign last_s       = ack_in_s && !circ_q && (state_q == ST_CAPTURE) && (count_q == CNT_LAST);
  assign capture_go_s = (state_q == ST_CAPTURE) && !abort_s && !last_s;
  assign slot_free_s  = !stb_q || ack_in_s;
  assign load_fifo_s  = capture_go_s && slot_free_s && !fifo_empty_s;
  // An empty FIFO lets a sample go straight to the bram master register.
  assign bypass_s     = capture_go_s && slot_free_s && fifo_empty_s && sample_valid_i;
  assign pop_s        = load_fifo_s;
  assign samp_in_s    = capture_go_s && sample_valid_i && !bypass_s;
  assign push_s       = samp_in_s && (!fifo_full_s || pop_s);
  assign drop_s       = samp_in_s && fifo_full_s && !pop_s;
  assign flush_s      = arm_s || abort_s || last_s;

  logging_sample_fifo #(
    .LOG2 (FIFO_LOG2),
    .W    (16)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (flush_s),
    .dat_i   (sample_dat_i),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .head_o  (fifo_head_s)
  );

  // Next-state logic for the capture FSM, pointer/count, flags and bram word.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    circ_d   = circ_q;
    wrap_d   = wrap_q;
    ovf_d    = ovf_q;
    stb_d    = stb_q;
    dat_d    = dat_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_s) begin
          state_d = ST_ARMED;
          circ_d  = sbus_wb_dat_i[CTRL_CIRC_BIT];
        end else begin
          state_d = state_q;
        end
      end
      ST_ARMED: begin
        if (abort_s) begin
          state_d = ST_IDLE;
        end else if (trig_i) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = state_q;
        end
      end
      ST_CAPTURE: begin
        if (abort_s || last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ack_in_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      count_d  = (count_q == CNT_FULL) ? count_q : (count_q + CNT_ONE);
      if (circ_q && (wr_ptr_q == PTR_LAST)) begin
        wrap_d = 1'b1;
      end else begin
        wrap_d = wrap_q;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (drop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end

    // adr/dat stay put while stb is high and no ack has arrived.
    if (slot_free_s) begin
      if (load_fifo_s) begin
        stb_d = 1'b1;
        dat_d = fifo_head_s;
      end else if (bypass_s) begin
        stb_d = 1'b1;
        dat_d = sample_dat_i;
      end else begin
        stb_d = 1'b0;
        dat_d = dat_q;
      end
    end else begin
      stb_d = stb_q;
      dat_d = dat_q;
    end

    if (arm_s) begin
      wr_ptr_d = '0;
      count_d  = '0;
      wrap_d   = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      circ_d = circ_d;
    end
  end

  // Capture FSM and bram master state registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
      circ_q   <= 1'b0;
      wrap_q   <= 1'b0;
      ovf_q    <= 1'b0;
      stb_q    <= 1'b0;
      dat_q    <= 16'h0000;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      circ_q   <= circ_d;
      wrap_q   <= wrap_d;
      ovf_q    <= ovf_d;
      stb_q    <= stb_d;
      dat_q    <= dat_d;
    end
  end

  // sbus read mux, sampled on the request cycle.
  always_comb begin
    case (sbus_wb_adr_i[2:1])
      REG_CTRL:  rdat_s = pack_status(state_q, circ_q, wrap_q, ovf_q);
      REG_PTR:   rdat_s = {{(16-PTR_W){1'b0}}, wr_ptr_q};
      REG_COUNT: rdat_s = {{(16-CNT_W){1'b0}}, count_q};
      REG_RSVD:  rdat_s = 16'h0000;
      default:   rdat_s = 16'h0000;
    endcase
  end

  // Registered single-cycle sbus ack with its read data.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q  <= 1'b0;
      rdat_q <= 16'h0000;
    end else begin
      ack_q  <= sbus_req_s;
      rdat_q <= sbus_req_s ? rdat_s : 16'h0000;
    end
  end

  assign sbus_wb_ack_o  = ack_q;
  assign sbus_wb_dat_o  = rdat_q;
  assign lbram_wb_cyc_o = stb_q;
  assign lbram_wb_stb_o = stb_q;
  assign lbram_wb_we_o  = stb_q;
  assign lbram_wb_adr_o = {{(ADR_W-PTR_W){1'b0}}, wr_ptr_q};
  assign lbram_wb_dat_o = dat_q;
  assign done_o         = (state_q == ST_DONE);

endmodule

// File: tb/tb_logging_capture_writer.sv
// Directed bench for logging_capture_writer with a bram write scoreboard.
module tb_logging_capture_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_cyc, s_stb, s_we;
  logic [15:0] s_adr, s_dat;
  logic [1:0]  s_sel;
  logic [15:0] s_rdat;
  logic        s_ack;
  logic        smp_v;
  logic [15:0] smp_d;
  logic        trig;
  logic        b_cyc, b_stb, b_we, b_ack;
  logic [11:0] b_adr;
  logic [15:0] b_dat;
  logic        done;
  logic        ack_en;

  int checks   = 0;
  int failures = 0;
  int stb_seen = 0;
  int exp_adr  = 0;

  typedef struct packed {
    logic [11:0] adr;
    logic [15:0] dat;
  } wr_t;
  wr_t exp_q[$];
  wr_t got_w, exp_w;

  always #5 clk = ~clk;

  assign b_ack = b_stb & ack_en;

  logging_capture_writer dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .sbus_wb_cyc_i  (s_cyc),
    .sbus_wb_stb_i  (s_stb),
    .sbus_wb_we_i   (s_we),
    .sbus_wb_adr_i  (s_adr),
    .sbus_wb_sel_i  (s_sel),
    .sbus_wb_dat_i  (s_dat),
    .sbus_wb_dat_o  (s_rdat),
    .sbus_wb_ack_o  (s_ack),
    .sample_valid_i (smp_v),
    .sample_dat_i   (smp_d),
    .trig_i         (trig),
    .lbram_wb_cyc_o (b_cyc),
    .lbram_wb_stb_o (b_stb),
    .lbram_wb_we_o  (b_we),
    .lbram_wb_adr_o (b_adr),
    .lbram_wb_dat_o (b_dat),
    .lbram_wb_ack_i (b_ack),
    .done_o         (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // bram write monitor: every acked write must match the scoreboard head.
  always @(negedge clk) begin
    if (b_stb) stb_seen++;
    if (b_stb && b_ack) begin
      got_w = '{adr: b_adr, dat: b_dat};
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL bram_unexpected observed=%h expected=none", got_w);
      end
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check("bram_write", {4'h0, got_w}, {4'h0, exp_w});
        check("bram_we", {31'd0, b_we}, 32'd1);
      end
    end
  end

  task automatic sbus_xfer(input logic we, input logic [1:0] rsel, input logic [15:0] wdat,
                           output logic [15:0] rdat);
    bit got;
    got  = 1'b0;
    rdat = 16'h0000;
    s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_adr = {13'd0, rsel, 1'b0}; s_dat = wdat;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (s_ack) begin
        got  = 1'b1;
        rdat = s_rdat;
      end
    end
    @(posedge clk); #1;
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    check("sbus_ack_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic sbus_wr(input logic [1:0] rsel, input logic [15:0] wdat);
    logic [15:0] dummy;
    sbus_xfer(1'b1, rsel, wdat, dummy);
  endtask

  task automatic sbus_chk(input string tag, input logic [1:0] rsel, input logic [15:0] exp);
    logic [15:0] r;
    sbus_xfer(1'b0, rsel, 16'h0000, r);
    check(tag, {16'd0, r}, {16'd0, exp});
  endtask

  task automatic send(input logic [15:0] d, input bit expect_wr);
    smp_v = 1'b1;
    smp_d = d;
    if (expect_wr) begin
      exp_q.push_back('{adr: 12'(exp_adr), dat: d});
      exp_adr = (exp_adr + 1) % 2048;
    end
    @(posedge clk); #1;
    smp_v = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (2) begin @(posedge clk); #1; end
    check(tag, exp_q.size(), 32'd0);
  endtask

  task automatic arm_and_trigger(input logic [15:0] ctrl);
    sbus_wr(2'd0, ctrl);
    trig = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    trig = 1'b0;
    exp_adr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int na;
    rst = 1'b1; s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0; s_adr = 16'h0000;
    s_dat = 16'h0000; s_sel = 2'b11; smp_v = 1'b0; smp_d = 16'h0000;
    trig = 1'b0; ack_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check("rst_sbus_ack", {31'd0, s_ack}, 32'd0);
    check("rst_sbus_dat", {16'd0, s_rdat}, 32'd0);
    check("rst_cyc", {31'd0, b_cyc}, 32'd0);
    check("rst_stb", {31'd0, b_stb}, 32'd0);
    check("rst_we", {31'd0, b_we}, 32'd0);
    check("rst_adr", {20'd0, b_adr}, 32'd0);
    check("rst_dat", {16'd0, b_dat}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    sbus_chk("rst_ctrl", 2'd0, 16'h0000);
    sbus_chk("rst_ptr", 2'd1, 16'h0000);
    sbus_chk("rst_count", 2'd2, 16'h0000);
    sbus_chk("rsvd_reg", 2'd3, 16'h0000);

    // 1: one-shot full buffer
    sbus_wr(2'd0, 16'h0001);
    sbus_chk("t1_armed", 2'd0, 16'h0001);
    trig = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    trig = 1'b0;
    sbus_chk("t1_capture", 2'd0, 16'h0002);
    exp_adr = 0;
    send(16'd0, 1'b1);
    check("t1_latency_stb", {31'd0, b_stb}, 32'd1);
    for (int i = 1; i < 2048; i++) send(16'(i), 1'b1);
    drain("t1_drain");
    check("t1_done", {31'd0, done}, 32'd1);
    sbus_chk("t1_ctrl", 2'd0, 16'h0003);
    sbus_chk("t1_count", 2'd2, 16'd2048);
    sbus_chk("t1_ptr", 2'd1, 16'd0);

    // 2: circular with wrap
    arm_and_trigger(16'h0003);
    for (int i = 0; i < 2050; i++) send(16'(i), 1'b1);
    drain("t2_drain");
    sbus_chk("t2_ctrl", 2'd0, 16'h000E);
    sbus_chk("t2_ptr", 2'd1, 16'd2);
    sbus_chk("t2_count", 2'd2, 16'd2048);
    sbus_wr(2'd0, 16'h0004);
    sbus_chk("t2_abort_ctrl", 2'd0, 16'h000F);
    check("t2_done", {31'd0, done}, 32'd1);

    // 3: stalled bram, overflow
    arm_and_trigger(16'h0001);
    ack_en = 1'b0;
    for (int i = 0; i < 6; i++) send(16'hA000 + 16'(i), (i < 5));
    repeat (4) begin @(posedge clk); #1; end
    check("t3_stb_held", {31'd0, b_stb}, 32'd1);
    check("t3_adr_held", {20'd0, b_adr}, 32'd0);
    check("t3_dat_held", {16'd0, b_dat}, 32'h0000A000);
    ack_en = 1'b1;
    drain("t3_drain");
    sbus_chk("t3_ctrl_ovf", 2'd0, 16'h0012);
    sbus_chk("t3_count", 2'd2, 16'd5);
    sbus_wr(2'd0, 16'h0004);
    sbus_chk("t3_abort_ctrl", 2'd0, 16'h0013);

    // 4: abort with a write in flight
    arm_and_trigger(16'h0001);
    ack_en = 1'b0;
    send(16'hB000, 1'b1);
    send(16'hB001, 1'b0);
    sbus_wr(2'd0, 16'h0004);
    sbus_chk("t4_ctrl_done", 2'd0, 16'h0003);
    check("t4_stb_pending", {31'd0, b_stb}, 32'd1);
    ack_en = 1'b1;
    drain("t4_drain");
    s0 = stb_seen;
    repeat (6) begin @(posedge clk); #1; end
    check("t4_no_more_stb", stb_seen - s0, 32'd0);
    sbus_chk("t4_count", 2'd2, 16'd1);
    sbus_chk("t4_ptr", 2'd1, 16'd1);

    // 5: abort and trigger together in ARMED, then arm while capturing
    sbus_wr(2'd0, 16'h0001);
    s0 = stb_seen;
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = 16'h0000; s_dat = 16'h0004;
    @(posedge clk); #1;
    check("t5_abort_ack", {31'd0, s_ack}, 32'd1);
    trig = 1'b1;
    @(posedge clk); #1;
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0; trig = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    sbus_chk("t5_ctrl_idle", 2'd0, 16'h0000);
    check("t5_no_stb", stb_seen - s0, 32'd0);
    arm_and_trigger(16'h0001);
    for (int i = 0; i < 3; i++) send(16'hC000 + 16'(i), 1'b1);
    drain("t5_drain");
    sbus_wr(2'd0, 16'h0003);
    sbus_chk("t5_arm_ignored", 2'd0, 16'h0002);
    sbus_chk("t5_ptr", 2'd1, 16'd3);

    // 6: reset in the middle of a bram write
    ack_en = 1'b0;
    send(16'hD000, 1'b0);
    check("t6_stb_before", {31'd0, b_stb}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_cyc_after", {31'd0, b_cyc}, 32'd0);
    check("t6_stb_after", {31'd0, b_stb}, 32'd0);
    rst = 1'b0;
    ack_en = 1'b1;
    sbus_chk("t6_ctrl", 2'd0, 16'h0000);
    sbus_chk("t6_ptr", 2'd1, 16'h0000);
    sbus_chk("t6_count", 2'd2, 16'h0000);
    check("t6_done", {31'd0, done}, 32'd0);

    // sbus ack is one cycle wide while stb is held over three cycles
    na = 0;
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 16'h0000;
    if (s_ack) na++;
    @(posedge clk); #1;
    if (s_ack) na++;
    @(posedge clk); #1;
    if (s_ack) na++;
    s_cyc = 1'b0; s_stb = 1'b0;
    check("ack_one_cycle", na, 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    check("ack_low_after", {31'd0, s_ack}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
